// File: rtl/uart_bootloader.sv
// uart_bootloader: receives a framed program image from the UART byte
// interface, writes it word by word into instruction ROM and holds the core
// in reset until the image checksum verifies.
module uart_bootloader #(
  parameter int unsigned ROM_DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_flag,
  output logic                  rx_flag_clr,
  output logic                  rom_wren,
  output logic [ADDR_WIDTH-1:0] rom_wraddr,
  output logic [31:0]           rom_wrdata,
  output logic                  core_rst,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Timer saturates at TIMEOUT_CYCLES-1; the step onto that value is the expiry.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_PRE  = TMR_W'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0]       HEADER   = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StData,
    StCheck,
    StDone,
    StError
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      count_q;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           word_q;
  logic [7:0]            csum_q;
  logic [TMR_W-1:0]      tmr_q;
  logic                  consume;
  logic                  timed;

  // rx_flag_clr is high exactly in the cycle after a consume, which makes it the blind cycle.
  // DONE leaves the flag to the core's own UART path.
  assign consume = rx_flag & ~rx_flag_clr & (state != StDone);
  assign timed   = (state == StCount) | (state == StData) | (state == StCheck);

  // Frame FSM with registered outputs, byte assembly, checksum and inter-byte timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      rx_flag_clr  <= 1'b0;
      rom_wren     <= 1'b0;
      rom_wraddr   <= '0;
      rom_wrdata   <= '0;
      core_rst     <= 1'b1;
      boot_done    <= 1'b0;
      boot_error   <= 1'b0;
      words_loaded <= '0;
      count_q      <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      tmr_q        <= '0;
    end else begin
      rx_flag_clr <= consume;
      rom_wren    <= 1'b0;

      if (consume) begin
        tmr_q <= '0;
      end else if (timed) begin
        if (tmr_q != TMR_LAST) begin
          tmr_q <= tmr_q + TMR_W'(1);
        end
        if (tmr_q == TMR_PRE) begin
          state      <= StError;
          boot_error <= 1'b1;
        end
      end

      unique case (state)
        StIdle, StError: begin
          // Non-header bytes are consumed and dropped.
          if (consume && rx_data == HEADER) begin
            state        <= StCount;
            boot_error   <= 1'b0;
            words_loaded <= '0;
          end
        end
        StCount: begin
          if (consume) begin
            if (rx_data == 8'd0 || 32'(rx_data) > ROM_DEPTH) begin
              state      <= StError;
              boot_error <= 1'b1;
            end else begin
              count_q  <= CNT_W'(rx_data);
              word_idx <= '0;
              byte_idx <= '0;
              csum_q   <= '0;
              state    <= StData;
            end
          end
        end
        StData: begin
          if (consume) begin
            csum_q   <= csum_q ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_q[7:0]   <= rx_data;
              2'd1: word_q[15:8]  <= rx_data;
              2'd2: word_q[23:16] <= rx_data;
              2'd3: begin
                rom_wren     <= 1'b1;
                rom_wraddr   <= word_idx;
                rom_wrdata   <= {rx_data, word_q};
                words_loaded <= words_loaded + CNT_W'(1);
                if ({1'b0, word_idx} == count_q - CNT_W'(1)) begin
                  state <= StCheck;
                end else begin
                  word_idx <= word_idx + ADDR_WIDTH'(1);
                end
              end
              default: ;
            endcase
          end
        end
        StCheck: begin
          if (consume) begin
            if (rx_data == csum_q) begin
              state     <= StDone;
              boot_done <= 1'b1;
              core_rst  <= 1'b0;
            end else begin
              state      <= StError;
              boot_error <= 1'b1;
            end
          end
        end
        StDone: ;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bootloader.sv
// tb_uart_bootloader: scoreboard bench for the UART image loader.
`timescale 1ns/1ps
module tb_uart_bootloader;

  localparam int unsigned ROM_DEPTH      = 64;
  localparam int unsigned ADDR_WIDTH     = 6;
  localparam int unsigned TIMEOUT_CYCLES = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_flag = 1'b0;
  logic        rx_flag_clr;
  logic        rom_wren;
  logic [5:0]  rom_wraddr;
  logic [31:0] rom_wrdata;
  logic        core_rst;
  logic        boot_done;
  logic        boot_error;
  logic [6:0]  words_loaded;

  uart_bootloader #(
    .ROM_DEPTH     (ROM_DEPTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_flag     (rx_flag),
    .rx_flag_clr (rx_flag_clr),
    .rom_wren    (rom_wren),
    .rom_wraddr  (rom_wraddr),
    .rom_wrdata  (rom_wrdata),
    .core_rst    (core_rst),
    .boot_done   (boot_done),
    .boot_error  (boot_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [37:0] exp_q[$];
  logic [37:0] act_q[$];
  logic [31:0] frame_words[$];
  int          clr_pulses   = 0;
  int          clr_back2back = 0;
  logic        clr_prev     = 1'b0;

  logic [49:0] out_vec;
  assign out_vec = {rx_flag_clr, rom_wren, rom_wraddr, rom_wrdata,
                    core_rst, boot_done, boot_error, words_loaded};
  localparam logic [49:0] RESET_VEC = {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 7'd0};

  // Capture every ROM write and clear pulse away from the active edge.
  always @(negedge clk) begin
    if (rom_wren) act_q.push_back({rom_wraddr, rom_wrdata});
    if (rx_flag_clr) clr_pulses <= clr_pulses + 1;
    if (rx_flag_clr && clr_prev) clr_back2back <= clr_back2back + 1;
    clr_prev <= rx_flag_clr;
  end

  // UART model: hold the flag until the clear pulse is seen, then drop it.
  task automatic send_byte(input logic [7:0] b);
    bit seen = 1'b0;
    rx_data = b;
    rx_flag = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rx_flag_clr) seen = 1'b1;
    end
    rx_flag = 1'b0;
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL send_byte %02h: rx_flag_clr=0 after 20 cycles, required 1", b);
    end
  endtask

  // Sends header, count, data and checksum XOR csum_flip; expected writes go to exp_q.
  task automatic send_frame(input logic [7:0] csum_flip);
    logic [7:0] x = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(frame_words.size()));
    foreach (frame_words[w]) begin
      exp_q.push_back({6'(w), frame_words[w]});
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = frame_words[w][8*k +: 8];
        x = x ^ b;
        send_byte(b);
      end
    end
    send_byte(x ^ csum_flip);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    act_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_vec !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h, required %h", out_vec, RESET_VEC);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (core_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle_core_rst: got %b, required 1", core_rst);
    end
  endtask

  task automatic test_good_frame();
    int base;
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    send_frame(8'h00);
    n_checks++;
    if ({boot_done, core_rst, boot_error} !== 3'b100) begin
      n_fail++;
      $display("FAIL good_status: done/core_rst/err got %b, required 100",
               {boot_done, core_rst, boot_error});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (words_loaded !== 7'd2) begin
      n_fail++;
      $display("FAIL good_words_loaded: got %0d, required 2", words_loaded);
    end
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL good_write_count: got %0d, required %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      logic [37:0] e, a;
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL good_write: addr/data got %h, required %h", a, e);
      end
    end
    // DONE must leave the RX flag alone.
    base = clr_pulses;
    rx_flag = 1'b1;
    repeat (5) @(negedge clk);
    rx_flag = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (clr_pulses - base !== 0) begin
      n_fail++;
      $display("FAIL done_no_consume: clr pulses got %0d, required 0", clr_pulses - base);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    send_frame(8'h11);
    n_checks++;
    if ({boot_done, core_rst, boot_error} !== 3'b011) begin
      n_fail++;
      $display("FAIL badsum_status: done/core_rst/err got %b, required 011",
               {boot_done, core_rst, boot_error});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (act_q.size() !== 2) begin
      n_fail++;
      $display("FAIL badsum_write_count: got %0d, required 2", act_q.size());
    end
    exp_q.delete();
    act_q.delete();
    send_frame(8'h00);
    n_checks++;
    if ({boot_done, core_rst, boot_error} !== 3'b100) begin
      n_fail++;
      $display("FAIL resend_status: done/core_rst/err got %b, required 100",
               {boot_done, core_rst, boot_error});
    end
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      logic [37:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 38'h0;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL resend_write: addr/data got %h, required %h", a, e);
      end
    end
  endtask

  task automatic test_bad_count();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    n_checks++;
    if (boot_error !== 1'b1) begin
      n_fail++;
      $display("FAIL count_zero: boot_error got %b, required 1", boot_error);
    end
    send_byte(8'hA5);
    n_checks++;
    if ({boot_error, core_rst} !== 2'b01) begin
      n_fail++;
      $display("FAIL error_header_clear: err/core_rst got %b, required 01", {boot_error, core_rst});
    end
    send_byte(8'h41);
    n_checks++;
    if (boot_error !== 1'b1) begin
      n_fail++;
      $display("FAIL count_over: boot_error got %b, required 1", boot_error);
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({act_q.size(), 32'(words_loaded)} !== {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL count_no_write: writes %0d words_loaded %0d, required 0 0",
               act_q.size(), words_loaded);
    end
  endtask

  task automatic test_garbage_then_frame();
    int base;
    do_reset();
    #1;
    base = clr_pulses;
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    #1;
    n_checks++;
    if (clr_pulses - base !== 2 || clr_back2back !== 0) begin
      n_fail++;
      $display("FAIL garbage_clr: pulses %0d back2back %0d, required 2 0",
               clr_pulses - base, clr_back2back);
    end
    n_checks++;
    if ({boot_error, core_rst, boot_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL garbage_status: err/core_rst/done got %b, required 010",
               {boot_error, core_rst, boot_done});
    end
    frame_words = '{32'hDEAD_BEEF};
    send_frame(8'h00);
    @(negedge clk);
    #1;
    n_checks++;
    if ({boot_done, core_rst, words_loaded} !== {1'b1, 1'b0, 7'd1}) begin
      n_fail++;
      $display("FAIL garbage_frame: done %b core_rst %b words %0d, required 1 0 1",
               boot_done, core_rst, words_loaded);
    end
    while (exp_q.size() > 0) begin
      logic [37:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 38'h0;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL garbage_write: addr/data got %h, required %h", a, e);
      end
    end
  endtask

  task automatic test_timeout();
    int waited = 0;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    // Now in the cycle after the last consume; error lands 100 cycles after the consume.
    while (boot_error !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited !== 99) begin
      n_fail++;
      $display("FAIL timeout_latency: cycles after clr got %0d, required 99", waited);
    end
    #1;
    n_checks++;
    if ({act_q.size(), 32'(words_loaded), 32'(core_rst)} !== {32'd0, 32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL timeout_no_write: writes %0d words %0d core_rst %b, required 0 0 1",
               act_q.size(), words_loaded, core_rst);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    exp_q.push_back({6'd0, 32'h1122_3344});
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    send_byte(8'h88);
    send_byte(8'h77);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_vec !== RESET_VEC) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h, required %h", out_vec, RESET_VEC);
    end
    n_checks++;
    if (act_q.size() !== 1 || act_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL midframe_writes: count %0d, required 1 write of %h", act_q.size(), exp_q[0]);
    end
    exp_q.delete();
    act_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    // Flag lingers through the blind cycle: one consume only.
    base = clr_pulses;
    rx_data = 8'h00;
    rx_flag = 1'b1;
    repeat (2) @(negedge clk);
    rx_flag = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (clr_pulses - base !== 1) begin
      n_fail++;
      $display("FAIL flag_hold: clr pulses got %0d, required 1", clr_pulses - base);
    end
    frame_words = '{32'h0000_0013, 32'h0010_0093, 32'hFFFF_FFFF};
    send_frame(8'h00);
    @(negedge clk);
    #1;
    n_checks++;
    if ({boot_done, core_rst, words_loaded} !== {1'b1, 1'b0, 7'd3}) begin
      n_fail++;
      $display("FAIL fresh_frame: done %b core_rst %b words %0d, required 1 0 3",
               boot_done, core_rst, words_loaded);
    end
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL fresh_write_count: got %0d, required %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      logic [37:0] e, a;
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL fresh_write: addr/data got %h, required %h", a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_count();
    test_garbage_then_frame();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
